// File: rtl/add_sub_accumulator_pkg.sv
// Shared constants for the add/subtract accumulator: FSM encodings and op select values.
package add_sub_accumulator_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/four_bit_adder_subtractor.sv
// Combinational 4-bit adder/subtractor: m=0 gives A+B, m=1 gives A-B as A + ~B + 1.
module four_bit_adder_subtractor (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       m,
    output logic [3:0] Sum,
    output logic       Carry
);
    logic [4:0] full;

    // For subtract, Carry=1 means no borrow.
    assign full  = {1'b0, A} + {1'b0, B ^ {4{m}}} + {4'b0, m};
    assign Sum   = full[3:0];
    assign Carry = full[4];
endmodule

// File: rtl/add_sub_accumulator.sv
// Packetised add/subtract accumulator around one four_bit_adder_subtractor, with
// sticky signed overflow, saturating beat count and a valid/ready result port.
module add_sub_accumulator
    import add_sub_accumulator_pkg::*;
#(
    parameter int MAX_BEATS = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
    input  logic       in_op,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_acc,
    output logic       out_carry,
    output logic       out_ovf,
    output logic [3:0] out_count
);
    localparam logic [3:0] MAX_CNT = 4'(MAX_BEATS);

    logic [1:0] state;
    logic [3:0] acc;
    logic       carry;
    logic       ovf;
    logic [3:0] count;
    logic [3:0] sum;
    logic       sum_carry;
    logic       accept;
    logic       beat_ovf;

    four_bit_adder_subtractor u_addsub (
        .A     (acc),
        .B     (in_data),
        .m     (in_op),
        .Sum   (sum),
        .Carry (sum_carry)
    );

    assign in_ready  = (state != ST_DONE);
    assign out_valid = (state == ST_DONE);
    assign accept    = in_valid && in_ready;

    // Subtract flips the sign test because the effective operand is -B.
    assign beat_ovf = (in_op == OP_SUB)
                    ? (acc[3] != in_data[3]) && (sum[3] != acc[3])
                    : (acc[3] == in_data[3]) && (sum[3] != acc[3]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            acc   <= 4'd0;
            carry <= 1'b0;
            ovf   <= 1'b0;
            count <= 4'd0;
        end else begin
            case (state)
                ST_IDLE, ST_ACCUM: begin
                    if (accept) begin
                        acc   <= sum;
                        carry <= sum_carry;
                        ovf   <= ovf | beat_ovf;
                        count <= (count >= MAX_CNT) ? MAX_CNT : count + 4'd1;
                        state <= in_last ? ST_DONE : ST_ACCUM;
                    end
                end
                ST_DONE: begin
                    // acc must be 0 again so the next packet's first beat is 0 +/- in_data.
                    if (out_ready) begin
                        state <= ST_IDLE;
                        acc   <= 4'd0;
                        carry <= 1'b0;
                        ovf   <= 1'b0;
                        count <= 4'd0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign out_acc   = acc;
    assign out_carry = carry;
    assign out_ovf   = ovf;
    assign out_count = count;
endmodule

// File: tb/tb_add_sub_accumulator.sv
// Directed-vector bench: expected results go into a queue at issue time and a
// monitor pops and compares them whenever a result handshake occurs.
module tb_add_sub_accumulator;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       in_op;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_acc;
    logic       out_carry;
    logic       out_ovf;
    logic [3:0] out_count;

    typedef struct {
        logic [3:0] acc;
        logic       carry;
        logic       ovf;
        logic [3:0] count;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;

    add_sub_accumulator #(.MAX_BEATS(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_op     (in_op),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_carry (out_carry),
        .out_ovf   (out_ovf),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: compare on every result handshake.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 8'd1, 8'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_acc", {4'd0, out_acc}, {4'd0, e.acc});
                chk("out_carry", {7'd0, out_carry}, {7'd0, e.carry});
                chk("out_ovf", {7'd0, out_ovf}, {7'd0, e.ovf});
                chk("out_count", {4'd0, out_count}, {4'd0, e.count});
            end
        end
    end

    task automatic check_idle(input string tag);
        chk({tag, "_in_ready"}, {7'd0, in_ready}, 8'd1);
        chk({tag, "_out_valid"}, {7'd0, out_valid}, 8'd0);
        chk({tag, "_outs_zero"}, {out_acc, out_carry, out_ovf, 2'b0}, 8'd0);
        chk({tag, "_count_zero"}, {4'd0, out_count}, 8'd0);
    endtask

    // Called #1 after a posedge; returns #1 after the accepting edge.
    task automatic beat(input logic [3:0] d, input logic op, input logic last);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_op    = op;
        in_last  = last;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("beat_accept_timeout", 8'd1, 8'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic last_beat(input logic [3:0] d, input logic op, input logic [3:0] eacc,
                             input logic ecar, input logic eovf, input logic [3:0] ecnt);
        exp_t e;
        e.acc = eacc; e.carry = ecar; e.ovf = eovf; e.count = ecnt;
        exp_q.push_back(e);
        beat(d, op, 1'b1);
        chk("out_valid_latency", {7'd0, out_valid}, 8'd1);
        chk("in_ready_done", {7'd0, in_ready}, 8'd0);
    endtask

    task automatic wait_handshake();
        int n;
        n = 0;
        while (out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (out_valid) chk("handshake_timeout", 8'd1, 8'd0);
        check_idle("post_hs");
    endtask

    initial begin
        logic [3:0] h_acc;
        logic [2:0] h_flags;
        logic [3:0] h_cnt;
        rst = 1'b1; in_valid = 1'b0; in_data = 4'd0; in_op = 1'b0; in_last = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_idle("reset");

        // 13 + 3 wraps to 0 with carry, no signed overflow.
        beat(4'd13, 1'b0, 1'b0);
        last_beat(4'd3, 1'b0, 4'b0000, 1'b1, 1'b0, 4'd2);
        wait_handshake();

        // 15 - 3 = 12, no borrow.
        beat(4'd15, 1'b0, 1'b0);
        last_beat(4'd3, 1'b1, 4'b1100, 1'b1, 1'b0, 4'd2);
        wait_handshake();

        // -7 - 3 overflows to +6.
        beat(4'd9, 1'b0, 1'b0);
        last_beat(4'd3, 1'b1, 4'b0110, 1'b1, 1'b1, 4'd2);
        wait_handshake();

        // Single beat 0 - 1 borrows.
        last_beat(4'd1, 1'b1, 4'b1111, 1'b0, 1'b0, 4'd1);
        wait_handshake();

        // 20 x (+1): acc wraps to 4, count saturates, ovf set at 7->8, last beat 3+1 no carry.
        for (int i = 0; i < 19; i++) beat(4'd1, 1'b0, 1'b0);
        last_beat(4'd1, 1'b0, 4'b0100, 1'b0, 1'b1, 4'd15);
        wait_handshake();

        // Backpressure: 6 + 1 = 7 held for 5 cycles while in_valid pulses are ignored.
        out_ready = 1'b0;
        beat(4'd6, 1'b0, 1'b0);
        last_beat(4'd1, 1'b0, 4'b0111, 1'b0, 1'b0, 4'd2);
        h_acc = out_acc; h_flags = {out_carry, out_ovf, out_valid}; h_cnt = out_count;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            in_data  = 4'd5;
            in_last  = 1'b1;
            @(posedge clk); #1;
            chk("bp_in_ready", {7'd0, in_ready}, 8'd0);
            chk("bp_acc_stable", {4'd0, out_acc}, {4'd0, h_acc});
            chk("bp_flags_stable", {5'd0, out_carry, out_ovf, out_valid}, {5'd0, h_flags});
            chk("bp_count_stable", {4'd0, out_count}, {4'd0, h_cnt});
        end
        in_valid = 1'b0; in_last = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_idle("bp_release");

        // Reset mid-packet discards the open packet.
        beat(4'd2, 1'b0, 1'b0);
        beat(4'd3, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle("mid_reset");
        last_beat(4'd5, 1'b0, 4'b0101, 1'b0, 1'b0, 4'd1);
        wait_handshake();

        repeat (2) @(posedge clk);
        chk("queue_drained", 8'(exp_q.size()), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/add_sub_accumulator.md
# add_sub_accumulator

Sequential front-end that feeds the 4-bit adder/subtractor and consumes its result. It accepts a stream of 4-bit operands with per-beat add/subtract select and accumulates them into a 4-bit register. The datapath is one `four_bit_adder_subtractor` instance, with `A` = accumulator, `B` = operand and `m` = op. A packet ends on `in_last`; the block then presents the result, carry and overflow flags and beat count through a valid/ready output port.

## Interface
Parameters:
- `MAX_BEATS`, default 15: saturation value of the beat counter; must fit in 4 bits.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: operand beat valid.
- `in_ready` out 1: block can accept a beat.
- `in_data` in 4: operand, drives adder `B`.
- `in_op` in 1: 0 = add, 1 = subtract; drives adder `m`.
- `in_last` in 1: final beat of packet.
- `out_valid` out 1: result held and valid.
- `out_ready` in 1: downstream accepts result.
- `out_acc` out 4: accumulated result.
- `out_carry` out 1: adder `Carry` from the final beat. For subtract, 1 = no borrow.
- `out_ovf` out 1: sticky two's-complement overflow over the packet.
- `out_count` out 4: beats accepted in the packet, saturating at `MAX_BEATS`.

## Operation
- States:
  - IDLE: no packet open; accumulator is 0.
  - ACCUM: packet open.
  - DONE: result presented.
- Beat accept means `in_valid && in_ready`. `in_ready` = 1 in IDLE and ACCUM, 0 in DONE.
- On each accepted beat:
  - `acc <= Sum`.
  - `carry <= Carry`.
  - `count <= min(count + 1, MAX_BEATS)`.
  - `ovf <= ovf | beat_ovf`.
- `beat_ovf` definition:
  - Add: `acc[3] == in_data[3]` and `Sum[3] != acc[3]`.
  - Subtract: `acc[3] != in_data[3]` and `Sum[3] != acc[3]`.
- Arithmetic is modulo 16. There is no saturation on the accumulator; wrap-around is normal and is reported only through the flags.
- State transitions:
  - IDLE, beat accepted with `in_last` = 0 → ACCUM.
  - IDLE, beat accepted with `in_last` = 1 → DONE. A single-beat packet is legal.
  - ACCUM, beat accepted with `in_last` = 1 → DONE.
  - ACCUM, no beat → stay. There is no timeout.
  - DONE, `out_valid && out_ready` → IDLE. On this transition acc, carry, ovf and count all clear to 0.
- In DONE, `out_*` hold stable while `out_ready` = 0. `in_valid` is ignored because `in_ready` = 0.
- The first beat of a packet always uses acc = 0, so the first beat computes `0 ± in_data`.
- Reset mid-packet or in DONE discards everything. The state machine returns to IDLE and the pending result is lost.

## Timing
- Reset values: `in_ready` = 1 (after reset, IDLE); `out_valid`, `out_acc`, `out_carry`, `out_ovf` and `out_count` = 0.
- Throughput is one beat per cycle in IDLE and ACCUM.
- The adder is combinational within the accept cycle; acc is updated at the next edge.
- `out_valid` rises on the edge that accepts the `in_last` beat. Latency from last beat to result is 1 cycle.
- `in_ready` is a registered function of state only, with no combinational path from `out_ready`. One bubble cycle follows each result handshake.
- `out_acc`, `out_carry`, `out_ovf` and `out_count` are driven directly from registers. Outside DONE they show the running values.

## Structure
- Shared package/header holds:
  - state encodings `ST_IDLE`=2'd0, `ST_ACCUM`=2'd1, `ST_DONE`=2'd2;
  - `OP_ADD`=1'b0, `OP_SUB`=1'b1.
- The single sub-module is `four_bit_adder_subtractor`, instantiated unchanged.
- The overflow logic and the state machine live in this block.

## Test plan
- Add 13, then add 3 (last) → `out_acc`=0000, `out_carry`=1, `out_ovf`=0, `out_count`=2; `out_valid` 1 cycle after the last beat.
- Add 15, then sub 3 (last) → `out_acc`=1100, `out_carry`=1, `out_ovf`=0.
- Add 9, then sub 3 (last) → `out_acc`=0110, `out_carry`=1, `out_ovf`=1 (−7−3 overflows).
- Single beat sub 1 (last) → `out_acc`=1111, `out_carry`=0 (borrow), `out_ovf`=0, `out_count`=1.
- 20 beats of add 1, last on beat 20 → `out_acc`=0100, `out_count`=15.
- Backpressure case:
  - Hold `out_ready`=0 for 5 cycles in DONE → outputs stable, `in_ready`=0, `in_valid` pulses ignored.
  - Release `out_ready` → IDLE next cycle with all outputs 0.
- Reset case:
  - Assert `rst` after 2 beats of an open packet → next cycle in IDLE with all outputs at reset values.
  - A new packet of add 5 (last) then yields `out_acc`=0101.
